// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard controller.
// State enum, control-bundle struct and the canned bundles.
package hazard_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT,
    FLUSH
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic ctrl_sel;
    logic if_id_flush;
    logic ex_mem_flush;
  } ctrl_t;

  // Normal flow.
  localparam ctrl_t C_PASS =
    '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  // Hold PC and IF/ID, keep control flowing.
  localparam ctrl_t C_FREEZE =
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  // Hold front end, inject a bubble into EX.
  localparam ctrl_t C_BUBBLE =
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Redirect: clear IF/ID and EX/MEM control.
  localparam ctrl_t C_BRANCH =
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  // Second redirect cycle: bubble the wrong-path ID op.
  localparam ctrl_t C_KILL =
    '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard inputs and stall/flush outputs of the ID stage.
// master: pipeline side; slave: hazard_stall_ctrl.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5
);

  logic                  id_ex_memRead;
  logic [REG_ADDR_W-1:0] id_ex_rt;
  logic [REG_ADDR_W-1:0] if_id_rs;
  logic [REG_ADDR_W-1:0] if_id_rt;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  ctrl_sel;
  logic                  if_id_flush;
  logic                  ex_mem_flush;
  logic                  busy;

  modport master (
    output id_ex_memRead, id_ex_rt,
    output if_id_rs, if_id_rt,
    output branch_taken, mem_busy,
    input  pc_write, if_id_write, ctrl_sel,
    input  if_id_flush, ex_mem_flush, busy
  );

  modport slave (
    input  id_ex_memRead, id_ex_rt,
    input  if_id_rs, if_id_rt,
    input  branch_taken, mem_busy,
    output pc_write, if_id_write, ctrl_sel,
    output if_id_flush, ex_mem_flush, busy
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use compare between EX load and ID sources.
// Ports: mem_read, ex_rt, id_rs, id_rt in; load_use out.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use
);

  logic not_zero;

  // r0 is hardwired, a load into it never creates a dependency.
  assign not_zero = (ex_rt != REG_ADDR_W'(REG_ZERO));

  assign load_use = mem_read && not_zero &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core (Mealy outputs).
// Ports: clk, rst_n, hz (slave). Option HAZARD_PERF_CNT_EN adds stall_cycles/flush_events.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W        = DEFAULT_REG_ADDR_W,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]    flush_events
`endif
);

  localparam logic [2:0] STALL_INIT =
    3'(LOAD_STALL_CYCLES - 1);

  state_t     state;
  state_t     nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  ctrl_t      ctrl;
  logic       load_use;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .mem_read (hz.id_ex_memRead),
    .ex_rt    (hz.id_ex_rt),
    .id_rs    (hz.if_id_rs),
    .id_rt    (hz.if_id_rt),
    .load_use (load_use)
  );

  // Order of items is the hazard priority; MEM_WAIT
  // falls through to the RUN rules once memory is ready.
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    ctrl  = C_PASS;
    priority case (1'b1)
      hz.mem_busy: begin
        ctrl = C_FREEZE;
        nxt  = MEM_WAIT;
      end
      (state == FLUSH): begin
        ctrl = C_KILL;
        nxt  = RUN;
      end
      hz.branch_taken: begin
        ctrl = C_BRANCH;
        nxt  = FLUSH;
      end
      (state == LOAD_STALL): begin
        ctrl  = C_BUBBLE;
        cnt_n = cnt - 3'd1;
        nxt   = (cnt == 3'd1) ? RUN : LOAD_STALL;
      end
      load_use: begin
        ctrl  = C_BUBBLE;
        cnt_n = STALL_INIT;
        nxt   = (STALL_INIT != 3'd0) ? LOAD_STALL : RUN;
      end
      default: begin
        nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
    end
  end

  // Mealy outputs are forced low while reset is held.
  assign hz.pc_write     = rst_n & ctrl.pc_write;
  assign hz.if_id_write  = rst_n & ctrl.if_id_write;
  assign hz.ctrl_sel     = rst_n & ctrl.ctrl_sel;
  assign hz.if_id_flush  = rst_n & ctrl.if_id_flush;
  assign hz.ex_mem_flush = rst_n & ctrl.ex_mem_flush;
  assign hz.busy         = (state != RUN);

`ifdef HAZARD_PERF_CNT_EN
  logic enter_flush;

  assign enter_flush = (nxt == FLUSH) && (state != FLUSH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!ctrl.pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (enter_flush && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);
    end
  end
`else
  // Counters not built; stall/flush sequencing is unchanged.
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (1 and 3 stall
// cycles) against a cycle model plus literal expectations.
module tb_hazard_stall_ctrl;

  localparam int CW = 4;
  localparam int SAT = 15;

  logic       clk;
  logic       rst_n;
  logic       mb, br, mr;
  logic [4:0] ert, rs, rt;

  int vectors = 0;
  int miscompares = 0;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) if1 ();
  hazard_stall_ctrl_if #(.REG_ADDR_W(5)) if3 ();

  assign if1.id_ex_memRead = mr;
  assign if1.id_ex_rt      = ert;
  assign if1.if_id_rs      = rs;
  assign if1.if_id_rt      = rt;
  assign if1.branch_taken  = br;
  assign if1.mem_busy      = mb;
  assign if3.id_ex_memRead = mr;
  assign if3.id_ex_rt      = ert;
  assign if3.if_id_rs      = rs;
  assign if3.if_id_rt      = rt;
  assign if3.branch_taken  = br;
  assign if3.mem_busy      = mb;

`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] sc1, fe1, sc3, fe3;
`endif

  hazard_stall_ctrl #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(CW)
  ) d1 (
    .clk(clk), .rst_n(rst_n), .hz(if1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc1), .flush_events(fe1)
`endif
  );

  hazard_stall_ctrl #(
    .REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(CW)
  ) d3 (
    .clk(clk), .rst_n(rst_n), .hz(if3)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(sc3), .flush_events(fe3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: bubbles still owed, waiting-on-memory, flush pending.
  int stall_len [2] = '{1, 3};
  int owed [2] = '{0, 0};
  bit waiting [2] = '{0, 0};
  bit kill [2] = '{0, 0};
  int scnt [2] = '{0, 0};
  int fcnt [2] = '{0, 0};

  // Literal expectations handed over from the stimulus.
  int         lit_seq = 0;
  int         lit_seen = 0;
  string      lit_name = "";
  logic [5:0] lit1, lit3;
  int         lit_sc = -1;

  always @(negedge clk) begin
    logic [5:0] g [2];
    logic [5:0] e;
    logic       lu, bz, br_take;
    int         got_sc, got_fe;
    g[0] = {if1.pc_write, if1.if_id_write, if1.ctrl_sel,
            if1.if_id_flush, if1.ex_mem_flush, if1.busy};
    g[1] = {if3.pc_write, if3.if_id_write, if3.ctrl_sel,
            if3.if_id_flush, if3.ex_mem_flush, if3.busy};
    lu = mr && (ert != 0) && (ert == rs || ert == rt);
    for (int i = 0; i < 2; i++) begin
      got_sc = 0;
      got_fe = 0;
`ifdef HAZARD_PERF_CNT_EN
      got_sc = (i == 0) ? int'(sc1) : int'(sc3);
      got_fe = (i == 0) ? int'(fe1) : int'(fe3);
      vectors++;
      if (got_sc != scnt[i] || got_fe != fcnt[i]) begin
        miscompares++;
        $display("FAIL perf[%0d] t=%0t got sc=%0d fe=%0d exp sc=%0d fe=%0d",
                 i, $time, got_sc, got_fe, scnt[i], fcnt[i]);
      end
`endif
      br_take = 1'b0;
      if (!rst_n) begin
        e = 6'b000000;
        owed[i] = 0; waiting[i] = 0; kill[i] = 0;
        scnt[i] = 0; fcnt[i] = 0;
      end else begin
        bz = (owed[i] > 0) || waiting[i] || kill[i];
        if (mb) begin
          e = {5'b00100, bz};
          waiting[i] = 1; owed[i] = 0; kill[i] = 0;
        end else if (kill[i]) begin
          e = 6'b110001;
          kill[i] = 0;
        end else if (br) begin
          e = {5'b11011, bz};
          br_take = 1'b1;
          kill[i] = 1; owed[i] = 0; waiting[i] = 0;
        end else if (owed[i] > 0) begin
          e = 6'b000001;
          owed[i]--;
        end else if (lu) begin
          e = {5'b00000, bz};
          owed[i] = stall_len[i] - 1;
          waiting[i] = 0;
        end else begin
          e = {5'b11100, bz};
          waiting[i] = 0;
        end
        if (!e[5] && scnt[i] < SAT) scnt[i]++;
        if (br_take && fcnt[i] < SAT) fcnt[i]++;
      end
      vectors++;
      if (g[i] !== e) begin
        miscompares++;
        $display("FAIL model[%0d] t=%0t got=%b exp=%b",
                 i, $time, g[i], e);
      end
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      vectors++;
      if (g[0] !== lit1 || g[1] !== lit3) begin
        miscompares++;
        $display("FAIL %s got=%b/%b exp=%b/%b",
                 lit_name, g[0], g[1], lit1, lit3);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (lit_sc >= 0) begin
        vectors++;
        if (int'(sc3) != lit_sc) begin
          miscompares++;
          $display("FAIL %s_sc got=%0d exp=%0d",
                   lit_name, sc3, lit_sc);
        end
      end
`endif
    end
  end

  task automatic drive(input logic m, input logic b,
                       input logic r, input logic [4:0] e_rt,
                       input logic [4:0] s, input logic [4:0] t);
    @(posedge clk);
    #1;
    mb = m; br = b; mr = r; ert = e_rt; rs = s; rt = t;
  endtask

  task automatic idle();
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Expectation for the current cycle, order
  // {pc_write,if_id_write,ctrl_sel,if_id_flush,ex_mem_flush,busy}.
  task automatic expect_out(input string n,
                            input logic [5:0] a,
                            input logic [5:0] b);
    lit_name = n;
    lit1 = a;
    lit3 = b;
    lit_seq++;
  endtask

  initial begin
    rst_n = 1'b0;
    mb = 0; br = 0; mr = 0; ert = 0; rs = 0; rt = 0;
    expect_out("reset", 6'b000000, 6'b000000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_out("idle", 6'b111000, 6'b111000);
    repeat (3) idle();

    drive(0, 0, 1, 5'd8, 5'd8, 5'd0);
    expect_out("lu_first", 6'b000000, 6'b000000);
    idle();
    expect_out("lu_second", 6'b111000, 6'b000001);
    idle();
    expect_out("lu_third", 6'b111000, 6'b000001);
    idle();
    expect_out("lu_done", 6'b111000, 6'b111000);

    drive(0, 0, 1, 5'd0, 5'd0, 5'd0);
    expect_out("r0_nostall", 6'b111000, 6'b111000);
    idle();

    drive(0, 0, 1, 5'd5, 5'd1, 5'd5);
    expect_out("lu_rt", 6'b000000, 6'b000000);
    drive(0, 1, 0, 5'd0, 5'd0, 5'd0);
    expect_out("br_in_stall", 6'b110110, 6'b110111);
    idle();
    expect_out("flush_state", 6'b110001, 6'b110001);
    idle();
    expect_out("after_flush", 6'b111000, 6'b111000);

    drive(1, 1, 0, 5'd0, 5'd0, 5'd0);
    expect_out("mb_first", 6'b001000, 6'b001000);
    repeat (3) drive(1, 1, 0, 5'd0, 5'd0, 5'd0);
    expect_out("mb_fourth", 6'b001001, 6'b001001);
    drive(0, 1, 0, 5'd0, 5'd0, 5'd0);
    expect_out("mb_exit_br", 6'b110111, 6'b110111);
    idle();
    expect_out("mb_flush", 6'b110001, 6'b110001);
    idle();
    expect_out("mb_run", 6'b111000, 6'b111000);

    drive(1, 1, 1, 5'd8, 5'd8, 5'd0);
    expect_out("all_three", 6'b001000, 6'b001000);
    idle();
    expect_out("wait_exit", 6'b111001, 6'b111001);
    idle();

    drive(0, 0, 1, 5'd9, 5'd0, 5'd9);
    idle();
    #1 rst_n = 1'b0;
    expect_out("async_rst", 6'b000000, 6'b000000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_out("post_rst", 6'b111000, 6'b111000);

    repeat (3) drive(0, 0, 1, 5'd3, 5'd3, 5'd3);
    drive(0, 0, 1, 5'd3, 5'd3, 5'd3);
    expect_out("re_stall", 6'b000000, 6'b000000);
    repeat (4) idle();

    repeat (20) drive(1, 0, 0, 5'd0, 5'd0, 5'd0);
    lit_sc = SAT;
    expect_out("long_wait", 6'b001001, 6'b001001);
    idle();
    lit_sc = -1;
    repeat (3) idle();

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline hazard controller for the 5-stage core. Detects load-use and data-memory-wait hazards and taken branches. Sequences the stall and flush response: PC/IF-ID write enables, IF-ID/EX-MEM flushes, and the selector of the control-signal bubble mux in front of ID/EX. Sits in the ID stage beside the main control unit.

Parameters:
REG_ADDR_W, 5, register-index width
LOAD_STALL_CYCLES, 1, bubble cycles per load-use hazard (1..7)
CNT_W, 32, perf-counter width (optional feature only)

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
id_ex_memRead  in  1  instruction in EX is a load
id_ex_rt  in  REG_ADDR_W  load destination in EX
if_id_rs  in  REG_ADDR_W  source rs of instruction in ID
if_id_rt  in  REG_ADDR_W  source rt of instruction in ID
branch_taken  in  1  branch resolved taken in MEM stage
mem_busy  in  1  data memory not ready, pipeline must freeze
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
ctrl_sel  out  1  bubble-mux selector: 1 = pass control, 0 = zero control (bubble)
if_id_flush  out  1  clear IF/ID
ex_mem_flush  out  1  zero control bits entering EX/MEM
busy  out  1  FSM not in RUN

Behaviour:
- One clock (clk), rising edge. Reset is asynchronous, active-low (rst_n).
- Reset values (while rst_n=0): pc_write=0, if_id_write=0, ctrl_sel=0, if_id_flush=0, ex_mem_flush=0, busy=0, state=RUN, counter=0.
- Hazard signals:
  - load_use = id_ex_memRead && id_ex_rt!=0 && (id_ex_rt==if_id_rs || id_ex_rt==if_id_rt).
  - Register 0 never causes a stall.
- Outputs are Mealy: they react in the same cycle the hazard is seen, with zero latency.
- States: RUN, LOAD_STALL, MEM_WAIT, FLUSH.
- Priority in every state: mem_busy > branch_taken > load_use.
- RUN:
  - No hazard: pc_write=1, if_id_write=1, ctrl_sel=1, flushes=0.
  - mem_busy: pc_write=0, if_id_write=0, ctrl_sel=1; next MEM_WAIT.
  - branch_taken: pc_write=1, if_id_flush=1, ctrl_sel=0, ex_mem_flush=1; next FLUSH.
  - load_use: pc_write=0, if_id_write=0, ctrl_sel=0; cnt=LOAD_STALL_CYCLES-1. Next is LOAD_STALL if cnt!=0, else RUN.
- LOAD_STALL:
  - Outputs as the load_use case; cnt decrements each cycle.
  - cnt==0 -> RUN. The hazard is then re-evaluated, and a new load_use in RUN re-stalls.
  - mem_busy preempts -> MEM_WAIT; remaining stall cycles are discarded.
  - branch_taken preempts -> FLUSH.
- MEM_WAIT:
  - Freeze: pc_write=0, if_id_write=0, ctrl_sel=1, flushes=0.
  - Exits to RUN the first cycle mem_busy=0. The RUN outputs of that cycle apply.
  - branch_taken is ignored while mem_busy=1. The MEM stage is frozen, so branch_taken stays asserted and is taken on exit.
- FLUSH:
  - One cycle. pc_write=1, if_id_write=1, ctrl_sel=0, if_id_flush=0, ex_mem_flush=0.
  - Kills the wrong-path instruction that was in ID. Next RUN.
  - mem_busy here -> MEM_WAIT with freeze outputs.
- busy=1 in every state except RUN.
- Reset mid-stall or mid-flush: immediate return to reset values; no residual counter.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cycles[CNT_W-1:0] and flush_events[CNT_W-1:0].
  - stall_cycles increments each cycle pc_write=0.
  - flush_events increments on each RUN/LOAD_STALL->FLUSH transition.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and logic absent; core behaviour identical.

Decomposition:
- Shared package hazard_pkg:
  - state enum {RUN, LOAD_STALL, MEM_WAIT, FLUSH}
  - localparam REG_ZERO=0
  - default REG_ADDR_W
- One sub-module: hazard_detect. Purely combinational load_use compare, reused later by the forwarding unit.
- FSM, counter and perf counters stay in hazard_stall_ctrl.

Test Plan:
- Reset, then idle with no hazards -> pc_write=1, if_id_write=1, ctrl_sel=1, busy=0 every cycle.
- id_ex_memRead=1, id_ex_rt=8, if_id_rs=8, LOAD_STALL_CYCLES=1 -> exactly 1 cycle of pc_write=0, ctrl_sel=0. With rt=0: no stall.
- LOAD_STALL_CYCLES=3, load_use pulse -> 3 bubble cycles. branch_taken in 2nd cycle -> that cycle has if_id_flush=1, ex_mem_flush=1; next cycle FLUSH; then RUN.
- mem_busy high 4 cycles with branch_taken=1 -> 4 freeze cycles, then flush, then FLUSH, then RUN.
- Simultaneous mem_busy, branch_taken and load_use in RUN -> MEM_WAIT outputs. Assert rst_n=0 asynchronously mid-LOAD_STALL -> outputs reach reset values before the next edge.
- HAZARD_PERF_CNT_EN with CNT_W=4 -> 20 stall cycles leave stall_cycles=15 (saturated).
